// File: rtl/proc_pkg.sv
// Shared processor-core constants and the fetch-unit state type.
package proc_pkg;
  localparam int PC_W        = 10;
  localparam int INSTR_W     = 16;
  localparam int STACK_DEPTH = 4;
  localparam int RESET_PC    = 0;

  typedef enum logic [1:0] {BOOT, RUN, HALTED} fetch_state_e;
endpackage

// File: rtl/ret_stack.sv
// Hardware return-address LIFO; push wins over a simultaneous pop.
module ret_stack #(
  parameter int DEPTH = proc_pkg::STACK_DEPTH,
  parameter int WIDTH = proc_pkg::PC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic [SP_W-1:0]  sp_q, sp_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, top_idx;
  logic             do_push;

  assign full    = (sp_q == SP_W'(DEPTH));
  assign empty   = (sp_q == '0);
  assign do_push = push && !full;
  assign wr_idx  = IDX_W'(sp_q);
  assign top_idx = IDX_W'(sp_q - SP_W'(1));
  assign dout    = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (do_push)                    sp_d = sp_q + SP_W'(1);
    else if (pop && !push && !empty) sp_d = sp_q - SP_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sp_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      sp_q <= sp_d;
      if (do_push) mem_q[wr_idx] <= din;
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, instruction register with valid/ready hand-off,
// jump/call/return redirects backed by ret_stack.
module fetch_unit #(
  parameter int              PC_W        = proc_pkg::PC_W,
  parameter int              INSTR_W     = proc_pkg::INSTR_W,
  parameter int              STACK_DEPTH = proc_pkg::STACK_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC    = PC_W'(proc_pkg::RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    pm_addr,
  input  logic [INSTR_W-1:0] pm_rd,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jump_en,
  input  logic               call_en,
  input  logic               ret_en,
  input  logic [PC_W-1:0]    target,
  output logic               stack_ovf,
  output logic               halted
);
  import proc_pkg::*;

  fetch_state_e       state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [PC_W-1:0]    ipc_q, ipc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               valid_q, valid_d;
  logic               ovf_q, ovf_d;
  logic               advance, accept;
  logic               stk_push, stk_pop, stk_full, stk_empty;
  logic [PC_W-1:0]    stk_dout;

  ret_stack #(.DEPTH(STACK_DEPTH), .WIDTH(PC_W)) u_ret_stack (
    .clk   (clk),
    .reset (reset),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (ipc_q + PC_W'(1)),
    .dout  (stk_dout),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign advance = (state_q == RUN) && (!valid_q || instr_ready);
  assign accept  = valid_q && instr_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ipc_d    = ipc_q;
    instr_d  = instr_q;
    valid_d  = valid_q;
    ovf_d    = ovf_q;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (advance) begin
          // Redirects only take effect on the edge that accepts the instruction
          if (accept && ret_en) begin
            valid_d = 1'b0;
            if (stk_empty) begin
              state_d = HALTED;
            end else begin
              stk_pop = 1'b1;
              pc_d    = stk_dout;
            end
          end else if (accept && call_en) begin
            valid_d = 1'b0;
            pc_d    = target;
            if (stk_full) ovf_d    = 1'b1;
            else          stk_push = 1'b1;
          end else if (accept && jump_en) begin
            valid_d = 1'b0;
            pc_d    = target;
          end else begin
            instr_d = pm_rd;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_W'(1);
          end
        end
      end
      HALTED:  valid_d = 1'b0;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign pm_addr     = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
  assign stack_ovf   = ovf_q;
  assign halted      = (state_q == HALTED);
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written call/ret/wrap/reset
// sequences, and a randomized run against a queue-based behavioural model.
module tb_fetch_unit;
  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [9:0]  pm_addr;
  logic [15:0] pm_rd;
  logic [15:0] instr;
  logic [9:0]  instr_pc;
  logic        instr_valid;
  logic        rdy = 1'b0, jmp = 1'b0, cal = 1'b0, rt = 1'b0;
  logic [9:0]  tgt = '0;
  logic        stack_ovf, halted;

  logic [15:0] mem [1024];
  assign pm_rd = mem[pm_addr];

  fetch_unit dut (
    .clk(clk), .reset(reset), .pm_addr(pm_addr), .pm_rd(pm_rd),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(rdy), .jump_en(jmp), .call_en(cal), .ret_en(rt),
    .target(tgt), .stack_ovf(stack_ovf), .halted(halted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Behavioural model: architectural PC, presented instruction, LIFO queue
  int m_pc, m_ipc, m_instr;
  bit m_valid, m_boot, m_halt, m_ovf;
  int m_stk[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_ipc = 0; m_instr = 0;
    m_valid = 0; m_boot = 1; m_halt = 0; m_ovf = 0;
    m_stk.delete();
  endtask

  task automatic model_step();
    bit acc;
    acc = m_valid && rdy;
    if (m_boot) m_boot = 0;
    else if (!m_halt && (!m_valid || rdy)) begin
      if (acc && rt) begin
        m_valid = 0;
        if (m_stk.size() == 0) m_halt = 1;
        else m_pc = m_stk.pop_back();
      end else if (acc && cal) begin
        if (m_stk.size() < 4) m_stk.push_back((m_ipc + 1) % 1024);
        else m_ovf = 1;
        m_pc = tgt; m_valid = 0;
      end else if (acc && jmp) begin
        m_pc = tgt; m_valid = 0;
      end else begin
        m_ipc = m_pc; m_instr = mem[m_pc]; m_valid = 1;
        m_pc = (m_pc + 1) % 1024;
      end
    end
  endtask

  task automatic compare_model();
    chk("model pm_addr", pm_addr, m_pc);
    chk("model instr_valid", instr_valid, m_valid);
    if (m_valid) begin
      chk("model instr_pc", instr_pc, m_ipc);
      chk("model instr", instr, m_instr);
    end
    chk("model halted", halted, m_halt);
    chk("model stack_ovf", stack_ovf, m_ovf);
  endtask

  task automatic tick(input bit r, input bit j, input bit c, input bit x, input logic [9:0] t);
    rdy = r; jmp = j; cal = c; rt = x; tgt = t;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic idle(); tick(H, L, L, L, 10'h000); endtask

  // Asserted mid-cycle; outputs must clear without waiting for a clock edge
  task automatic do_reset();
    rdy = 0; jmp = 0; cal = 0; rt = 0; tgt = '0;
    @(negedge clk);
    #2 reset = 1'b1;
    model_reset();
    #1;
    chk("reset pm_addr", pm_addr, 0);
    chk("reset instr", instr, 0);
    chk("reset instr_pc", instr_pc, 0);
    chk("reset instr_valid", instr_valid, 0);
    chk("reset stack_ovf", stack_ovf, 0);
    chk("reset halted", halted, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic expect_ipc(input string name, input logic [9:0] e);
    chk({name, " valid"}, instr_valid, 1);
    chk({name, " instr_pc"}, instr_pc, e);
    chk({name, " instr"}, instr, {6'd0, e});
  endtask

  task automatic expect_bubble(input string name);
    chk({name, " bubble"}, instr_valid, 0);
  endtask

  typedef struct {
    bit rdy, jmp, cal, ret;
    logic [9:0] tgt;
    bit ev;
    logic [9:0] eipc;
  } vec_t;
  vec_t vecs[$];

  task automatic add(input bit r, input bit j, input bit c, input bit x,
                     input logic [9:0] t, input bit ev, input logic [9:0] e);
    vec_t v;
    v.rdy = r; v.jmp = j; v.cal = c; v.ret = x; v.tgt = t; v.ev = ev; v.eipc = e;
    vecs.push_back(v);
  endtask

  initial begin
    logic [9:0] rets [4];
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i);

    // Vector table: inputs for one cycle, expected outputs after its edge
    add(H,L,L,L,10'h000, L,10'h000);
    add(H,L,L,L,10'h000, H,10'h000);
    add(H,L,L,L,10'h000, H,10'h001);
    add(H,L,L,L,10'h000, H,10'h002);
    add(H,L,L,L,10'h000, H,10'h003);
    add(H,H,L,L,10'h200, L,10'h000);
    add(H,L,L,L,10'h000, H,10'h200);
    add(H,H,L,L,10'h010, L,10'h000);
    add(H,L,L,L,10'h000, H,10'h010);
    add(H,L,H,L,10'h300, L,10'h000);
    add(H,L,L,L,10'h000, H,10'h300);
    add(H,L,L,L,10'h000, H,10'h301);
    add(H,L,L,L,10'h000, H,10'h302);
    add(H,L,L,H,10'h000, L,10'h000);
    add(H,L,L,L,10'h000, H,10'h011);
    add(H,L,L,L,10'h000, H,10'h012);
    add(L,H,L,L,10'h3ff, H,10'h012);
    add(H,L,L,L,10'h000, H,10'h013);
    add(H,H,L,L,10'h100, L,10'h000);
    add(H,H,L,L,10'h3ff, H,10'h100);
    add(H,L,L,L,10'h000, H,10'h101);

    do_reset();
    foreach (vecs[i]) begin
      tick(vecs[i].rdy, vecs[i].jmp, vecs[i].cal, vecs[i].ret, vecs[i].tgt);
      chk($sformatf("vec%0d valid", i), instr_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk($sformatf("vec%0d instr_pc", i), instr_pc, vecs[i].eipc);
        chk($sformatf("vec%0d instr", i), instr, {6'd0, vecs[i].eipc});
      end
    end

    // Stall while instr=5
    do_reset();
    idle(); expect_bubble("stall boot");
    repeat (6) idle();
    expect_ipc("stall pre", 10'd5);
    repeat (3) begin
      tick(L, L, L, L, 10'h000);
      expect_ipc("stall hold", 10'd5);
      chk("stall pm_addr", pm_addr, 6);
    end
    idle(); expect_ipc("stall resume", 10'd6);

    // Five nested calls, four returns, then return on an empty stack
    do_reset();
    idle(); idle(); expect_ipc("nest start", 10'd0);
    for (int k = 0; k < 5; k++) begin
      tick(H, L, H, L, 10'((k + 1) * 256));
      expect_bubble("nest call");
      chk($sformatf("nest ovf after call%0d", k + 1), stack_ovf, (k == 4));
      idle(); expect_ipc("nest target", 10'((k + 1) * 256));
    end
    rets[0] = 10'h301; rets[1] = 10'h201; rets[2] = 10'h101; rets[3] = 10'h001;
    for (int k = 0; k < 4; k++) begin
      tick(H, L, L, H, 10'h000);
      expect_bubble("nest ret");
      idle(); expect_ipc($sformatf("nest ret%0d", k + 1), rets[k]);
    end
    tick(H, L, L, H, 10'h000);
    chk("empty ret halted", halted, 1);
    expect_bubble("empty ret");
    repeat (3) begin
      tick(H, H, L, L, 10'h155);
      chk("halted stays", halted, 1);
      expect_bubble("halted");
      chk("halted pc frozen", pm_addr, 2);
    end

    // Wrap at 1023, call from 1023 pushes 0, ret right at the call target
    do_reset();
    idle(); idle(); expect_ipc("wrap start", 10'd0);
    tick(H, H, L, L, 10'd1022); expect_bubble("wrap jump");
    idle(); expect_ipc("wrap a", 10'd1022);
    idle(); expect_ipc("wrap b", 10'd1023);
    idle(); expect_ipc("wrap c", 10'd0);
    tick(H, H, L, L, 10'd1023); expect_bubble("c1023 jump");
    idle(); expect_ipc("c1023 at", 10'd1023);
    tick(H, L, H, L, 10'h050); expect_bubble("c1023 call");
    idle(); expect_ipc("c1023 target", 10'h050);
    tick(H, L, L, H, 10'h000); expect_bubble("c1023 ret");
    idle(); expect_ipc("c1023 return", 10'd0);
    idle(); idle();

    // Reset mid-stream, restart at RESET_PC two cycles later
    do_reset();
    idle(); expect_bubble("restart boot");
    idle(); expect_ipc("restart first", 10'd0);
    idle(); expect_ipc("restart second", 10'd1);

    // Randomized run against the model
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ((m_halt && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0)
        do_reset();
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 8) == 0, 10'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch unit for the processor core: the initiator on the program-memory read port. It drives the 10-bit word address into program memory, captures the 16-bit instruction word into an output register, and hands it to the decoder over a valid/ready handshake. It also owns the program counter, taken jumps, and a small hardware return-address stack for call/return.

## Interface
- `PC_W`, 10: program-counter and address width (1024-word memory).
- `INSTR_W`, 16: instruction width.
- `STACK_DEPTH`, 4: return-address stack entries.
- `RESET_PC`, 0: first fetch address after reset.

Ports (one clock `clk`; reset `reset` is asynchronous and active-high):
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high reset.
- `pm_addr`  out  PC_W  program-memory address; combinational copy of the PC register.
- `pm_rd`  in  INSTR_W  program-memory read data; combinational, same cycle.
- `instr`  out  INSTR_W  registered instruction word.
- `instr_pc`  out  PC_W  address `instr` was fetched from.
- `instr_valid`  out  1  `instr` holds a live instruction.
- `instr_ready`  in  1  decoder accepts `instr` this cycle.
- `jump_en`  in  1  the accepted instruction is a taken jump.
- `call_en`  in  1  the accepted instruction is a call.
- `ret_en`  in  1  the accepted instruction is a return.
- `target`  in  PC_W  jump/call destination.
- `stack_ovf`  out  1  sticky; set when a call hits a full stack.
- `halted`  out  1  set while in HALTED.

## Operation
- FSM has three states:
  - BOOT: the first cycle after reset release. `instr_valid`=0; moves to RUN.
  - RUN: normal operation; fetches and redirects as below.
  - HALTED: `instr_valid`=0 and the PC is frozen. Left only by reset.
- Definitions:
  - Advance = RUN && (!instr_valid || instr_ready).
  - Accept = instr_valid && instr_ready.
- Advance with no redirect:
  - instr <= pm_rd, instr_pc <= pc, instr_valid <= 1.
  - pc <= pc+1, modulo 2^PC_W (1023 wraps to 0).
- Redirect inputs are sampled only on Accept and ignored otherwise. Priority when several are high: ret > call > jump.
  - jump: pc <= target; instr_valid <= 0 (one bubble; the fall-through word is discarded).
  - call: push instr_pc+1 (mod 2^PC_W), pc <= target, bubble.
  - If a call finds the stack full: the push is dropped, stack_ovf <= 1 (sticky), and the jump is still taken.
  - ret with a non-empty stack: pop, pc <= popped value, bubble.
  - ret with an empty stack: go to HALTED, instr_valid <= 0.
- Not Advance (stalled): instr, instr_pc, instr_valid and pc all hold.
- Reset mid-operation clears everything immediately, including stack contents and pointer.

## Timing
- Reset values:
  - pc = RESET_PC, so pm_addr = RESET_PC.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - Stack pointer = 0, stack_ovf = 0, halted = 0, state = BOOT.
- First valid instruction (mem[RESET_PC]): 2 cycles after reset release (BOOT, then the first fetch edge).
- Throughput is 1 instruction/cycle while instr_ready=1.
- Taken redirect costs exactly 1 bubble cycle:
  - The edge that accepts the redirecting instruction loads pc <= target.
  - The next edge presents mem[target] with instr_valid=1.
- Call followed immediately by ret at the target works: the push completes on the call's Accept edge and is visible to the following pop.
- pm_addr changes only on clock edges; pm_rd must settle within the same cycle.

## Structure
- Shared package `proc_pkg`:
  - `PC_W` and `INSTR_W` constants.
  - `RESET_PC`.
  - Fetch-state enum `{BOOT, RUN, HALTED}`.
- Sub-module `ret_stack`: a LIFO of STACK_DEPTH×PC_W.
  - Inputs: push, pop, din.
  - Outputs: dout (top of stack), full, empty.
  - Asynchronous reset to empty.
  - On simultaneous push and pop: the pop is ignored (the fetch unit never issues both).
- Top level holds the FSM, the PC register, the instruction register and the redirect mux.

## Test plan
- Sequential fetch: memory loaded with mem[i]=i, instr_ready=1 -> after BOOT, instr = 0,1,2,… with instr_pc matching, one per cycle.
- Stall: drop instr_ready for 3 cycles while instr=5 -> instr, instr_pc and instr_valid hold at 5; resuming presents 6 next.
- Jump: accept instr_pc=3 with jump_en=1, target=0x200 -> one cycle with instr_valid=0, then instr_pc=0x200.
- Call/ret: call at pc 0x010 to 0x300, ret at 0x302 -> instr_pc sequence 0x300, 0x301, 0x302, bubble, 0x011.
- Call/ret boundaries:
  - 5 nested calls -> stack_ovf=1 after the 5th; 4 returns come back correctly.
  - A 5th ret -> halted=1, instr_valid stays 0.
  - Call at pc 1023 pushes 0.
- Wrap and reset: free-run from 1022 -> instr_pc 1022, 1023, 0. Assert reset mid-stream -> all outputs return to reset values at once; fetch restarts at RESET_PC after 2 cycles.
